// File: rtl/zspi_ports.sv
// Z80 SPI port block: config/status and data ports, mode-0 shifter, one-deep pending buffer.
// Optional loopback flag (CFG bit0) is compiled in with `define ZSPI_LOOPBACK_EN.
module zspi_ports #(
   parameter int         NCS       = 2,
   parameter int         DIV_W     = 8,
   parameter int         DIV_RESET = 3,
   parameter logic [7:0] CFG_PORT  = 8'h77,
   parameter logic [7:0] DAT_PORT  = 8'h57
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [15:0]    a,
   input  logic [7:0]     din,
   input  logic           iorq_n,
   input  logic           rd_n,
   input  logic           wr_n,
   output logic [7:0]     dout,
   output logic           dataout,
   output logic           porthit,
   output logic [NCS-1:0] spi_cs_n,
   output logic           spi_sck,
   output logic           spi_mosi,
   input  logic           spi_miso,
   output logic           busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } state_t;

   logic             iowr_r;
   logic             iord_r;
   logic             port_wr_s;
   logic             port_rd_s;
   logic             cfg_hit_s;
   logic             dat_hit_s;
   logic             cfg_wr_s;
   logic             ovr_clr_s;
   logic             ovr_set_s;
   logic             busy_st_s;
   logic             req_s;
   logic [7:0]       req_tx_s;
   logic             start_s;
   logic [7:0]       start_tx_s;
   logic             samp_in_s;
   logic             loop_s;
   logic [3:0]       cs_pad_s;
   logic             unused_s;

   logic [NCS-1:0]   cs_n_r;
   logic [DIV_W-1:0] div_r;
   state_t           state_r;
   logic [7:0]       shreg_r;
   logic [7:0]       rx_r;
   logic [7:0]       pend_tx_r;
   logic             pend_v_r;
   logic             ovr_r;
   logic             samp_r;
   logic             sck_r;
   logic             mosi_r;
   logic             busy_r;
   logic [DIV_W-1:0] h_r;
   logic [DIV_W-1:0] cnt_r;
   logic [2:0]       bit_r;

   assign cfg_hit_s = (a[7:0] == CFG_PORT);
   assign dat_hit_s = (a[7:0] == DAT_PORT);
   assign porthit   = cfg_hit_s | dat_hit_s;
   assign dataout   = porthit & ~iorq_n & ~rd_n;
   assign port_wr_s = ~(iorq_n | wr_n) & ~iowr_r;
   assign port_rd_s = ~(iorq_n | rd_n) & ~iord_r;
   assign cfg_wr_s  = port_wr_s & cfg_hit_s;
   assign ovr_clr_s = port_rd_s & cfg_hit_s;
   assign busy_st_s = (state_r != ST_IDLE);
   assign ovr_set_s = req_s & busy_st_s & pend_v_r;
   assign samp_in_s = loop_s ? mosi_r : spi_miso;
   assign unused_s  = ^a[14:8];

   assign spi_cs_n  = cs_n_r;
   assign spi_sck   = sck_r;
   assign spi_mosi  = mosi_r;
   assign busy      = busy_r;

   // Registered copies of the bus strobes, used to form one pulse per bus cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iowr_r <= 1'b0;
         iord_r <= 1'b0;
      end else begin
         iowr_r <= ~(iorq_n | wr_n);
         iord_r <= ~(iorq_n | rd_n);
      end
   end

   // Chip selects and divider; cs_n takes effect at once, div only at the next transfer start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_n_r <= {NCS{1'b1}};
         div_r  <= DIV_W'(DIV_RESET);
      end else if (cfg_wr_s) begin
         if (a[15]) begin
            div_r <= din[DIV_W-1:0];
         end else begin
            cs_n_r <= din[NCS:1];
         end
      end
   end

`ifdef ZSPI_LOOPBACK_EN
   logic loop_r;

   // Loopback flag shares the cs_n write (a[15]=0) on CFG bit0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loop_r <= 1'b0;
      end else if (cfg_wr_s && !a[15]) begin
         loop_r <= din[0];
      end
   end

   assign loop_s = loop_r;
`else
   assign loop_s = 1'b0;
`endif

   // Transfer request decode: DAT write sends din, DAT read sends a dummy FF.
   always_comb begin
      req_s    = 1'b0;
      req_tx_s = 8'hFF;
      if (dat_hit_s && port_wr_s) begin
         req_s    = 1'b1;
         req_tx_s = din;
      end else if (dat_hit_s && port_rd_s) begin
         req_s    = 1'b1;
         req_tx_s = 8'hFF;
      end else begin
         req_s    = 1'b0;
         req_tx_s = 8'hFF;
      end
   end

   // Start source: the pending byte always wins over a fresh request.
   always_comb begin
      start_s    = 1'b0;
      start_tx_s = req_tx_s;
      if (!busy_st_s && pend_v_r) begin
         start_s    = 1'b1;
         start_tx_s = pend_tx_r;
      end else if (!busy_st_s && req_s) begin
         start_s    = 1'b1;
         start_tx_s = req_tx_s;
      end else begin
         start_s    = 1'b0;
         start_tx_s = req_tx_s;
      end
   end

   // Pad cs_n to four bits with inactive ones for the status byte.
   always_comb begin
      cs_pad_s             = 4'hF;
      cs_pad_s[NCS-1:0]    = cs_n_r;
   end

   // Read mux; zero when not addressed so the top level can OR it in.
   always_comb begin
      if (cfg_hit_s) begin
         dout = {busy_r, ovr_r, pend_v_r, cs_pad_s, loop_s};
      end else if (dat_hit_s) begin
         dout = rx_r;
      end else begin
         dout = 8'h00;
      end
   end

   // Shifter FSM with pending buffer and overrun flag; sck phases last h_r+1 clocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         shreg_r   <= 8'hFF;
         rx_r      <= 8'hFF;
         pend_tx_r <= 8'hFF;
         pend_v_r  <= 1'b0;
         ovr_r     <= 1'b0;
         samp_r    <= 1'b1;
         sck_r     <= 1'b0;
         mosi_r    <= 1'b1;
         busy_r    <= 1'b0;
         h_r       <= {DIV_W{1'b0}};
         cnt_r     <= {DIV_W{1'b0}};
         bit_r     <= 3'd0;
      end else begin
         if (ovr_set_s) begin
            ovr_r <= 1'b1;
         end else if (ovr_clr_s) begin
            ovr_r <= 1'b0;
         end
         if (busy_st_s && req_s && !pend_v_r) begin
            pend_v_r  <= 1'b1;
            pend_tx_r <= req_tx_s;
         end
         case (state_r)
            ST_IDLE: begin
               if (pend_v_r) begin
                  pend_v_r <= req_s;
                  if (req_s) begin
                     pend_tx_r <= req_tx_s;
                  end
               end
               if (start_s) begin
                  state_r <= ST_LOW;
                  shreg_r <= start_tx_s;
                  h_r     <= div_r;
                  cnt_r   <= {DIV_W{1'b0}};
                  bit_r   <= 3'd0;
                  busy_r  <= 1'b1;
                  mosi_r  <= start_tx_s[7];
                  sck_r   <= 1'b0;
               end
            end
            ST_LOW: begin
               if (cnt_r == h_r) begin
                  cnt_r   <= {DIV_W{1'b0}};
                  sck_r   <= 1'b1;
                  samp_r  <= samp_in_s;
                  state_r <= ST_HIGH;
               end else begin
                  cnt_r <= cnt_r + DIV_W'(1);
               end
            end
            ST_HIGH: begin
               if (cnt_r == h_r) begin
                  cnt_r <= {DIV_W{1'b0}};
                  sck_r <= 1'b0;
                  if (bit_r == 3'd7) begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                     mosi_r  <= 1'b1;
                     rx_r    <= {shreg_r[6:0], samp_r};
                  end else begin
                     state_r <= ST_LOW;
                     shreg_r <= {shreg_r[6:0], samp_r};
                     mosi_r  <= shreg_r[6];
                     bit_r   <= bit_r + 3'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + DIV_W'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               sck_r   <= 1'b0;
               mosi_r  <= 1'b1;
            end
         endcase
      end
   end

endmodule
